// File: rtl/pet_stats_engine_if.sv
// Connection bundle between the input decoder, the pet stats engine and the status driver.
// The requester side drives enable, care actions and revive; the engine side returns stats and status.
interface pet_stats_engine_if #(
  parameter int NUM_STATS = 6,
  parameter int STAT_W    = 4
);
  logic                          ena;
  logic                          action_valid;
  logic [3:0]                    action_id;
  logic                          action_ready;
  logic                          revive;
  logic [NUM_STATS*STAT_W-1:0]   stats_flat;
  logic [NUM_STATS-1:0]          low_flags;
  logic [1:0]                    vital_state;
  logic                          tick;

  modport master (
    output ena, action_valid, action_id, revive,
    input  action_ready, stats_flat, low_flags, vital_state, tick
  );

  modport slave (
    input  ena, action_valid, action_id, revive,
    output action_ready, stats_flat, low_flags, vital_state, tick
  );
endinterface

// File: rtl/pet_stats_engine.sv
// Pet stats engine: saturating stat counters with LFSR-randomised periodic decay,
// care-action boosts over valid/ready, and an ALIVE/SICK/DEAD vitality machine.
module pet_stats_engine #(
  parameter int          NUM_STATS    = 6,
  parameter int          STAT_W       = 4,
  parameter int          TICK_COUNT   = 10_000_000,
  parameter int          INIT_VALUE   = 8,
  parameter int          BOOST        = 3,
  parameter int          LOW_THRESH   = 3,
  parameter int          DEATH_TICKS  = 4,
  parameter int          DECAY_RANDOM = 1,
  parameter logic [31:0] LFSR_SEED    = 32'h00001000
) (
  input logic               clk,
  input logic               rst_n,
  pet_stats_engine_if.slave bus
);

  localparam logic [1:0]  ST_ALIVE  = 2'b00;
  localparam logic [1:0]  ST_SICK   = 2'b01;
  localparam logic [1:0]  ST_DEAD   = 2'b10;
  localparam int          PRE_W     = (TICK_COUNT > 2) ? $clog2(TICK_COUNT) : 1;
  localparam int          CNT_W     = (DEATH_TICKS > 1) ? $clog2(DEATH_TICKS + 1) : 1;
  localparam int          FLAT_W    = NUM_STATS * STAT_W;
  localparam logic [31:0] LFSR_TAPS = 32'h80200003;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_COUNT - 1);
  localparam logic [STAT_W-1:0] STAT_MAX  = {STAT_W{1'b1}};
  localparam logic [FLAT_W-1:0] INIT_FLAT = {NUM_STATS{STAT_W'(INIT_VALUE)}};

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? LFSR_TAPS : 32'h0000_0000);
  endfunction

  function automatic logic [STAT_W-1:0] sat_dec(input logic [STAT_W-1:0] v, input logic [1:0] d);
    return (32'(v) > 32'(d)) ? STAT_W'(32'(v) - 32'(d)) : {STAT_W{1'b0}};
  endfunction

  function automatic logic [STAT_W-1:0] sat_boost(input logic [STAT_W-1:0] v);
    return ((32'(v) + 32'(BOOST)) > 32'(STAT_MAX)) ? STAT_MAX : STAT_W'(32'(v) + 32'(BOOST));
  endfunction

  function automatic logic [NUM_STATS-1:0] low_of(input logic [FLAT_W-1:0] f);
    logic [NUM_STATS-1:0] r;
    r = {NUM_STATS{1'b0}};
    for (int i = 0; i < NUM_STATS; i++) begin
      r[i] = (32'(f[i*STAT_W +: STAT_W]) < 32'(LOW_THRESH));
    end
    return r;
  endfunction

  logic [PRE_W-1:0]     presc_r;
  logic [31:0]          lfsr_r;
  logic                 tick_r;
  logic [FLAT_W-1:0]    stats_r;
  logic [NUM_STATS-1:0] low_r;
  logic [1:0]           state_r;
  logic [CNT_W-1:0]     cnt_r;

  logic                 dead_s;
  logic                 ready_s;
  logic                 xfer_s;
  logic                 decay_s;
  logic                 any_zero_s;
  logic [FLAT_W-1:0]    stats_nxt_s;
  logic [STAT_W-1:0]    cur_s;
  logic [STAT_W-1:0]    val_s;
  logic [1:0]           dec_s;
  logic [CNT_W-1:0]     cnt_inc_s;

  // Handshake qualification and the per-stat decay-then-boost datapath.
  always_comb begin
    dead_s      = (state_r == ST_DEAD);
    ready_s     = bus.ena && !dead_s;
    xfer_s      = bus.action_valid && ready_s;
    decay_s     = bus.ena && tick_r && !dead_s;
    cnt_inc_s   = cnt_r + CNT_W'(1);
    stats_nxt_s = stats_r;
    any_zero_s  = 1'b0;
    cur_s       = {STAT_W{1'b0}};
    val_s       = {STAT_W{1'b0}};
    dec_s       = 2'd1;
    for (int i = 0; i < NUM_STATS; i++) begin
      cur_s = stats_r[i*STAT_W +: STAT_W];
      dec_s = ((DECAY_RANDOM != 0) && lfsr_r[i]) ? 2'd2 : 2'd1;
      val_s = decay_s ? sat_dec(cur_s, dec_s) : cur_s;
      if (xfer_s && (32'(bus.action_id) == 32'(i))) begin
        val_s = sat_boost(val_s);
      end else begin
        val_s = val_s;
      end
      stats_nxt_s[i*STAT_W +: STAT_W] = val_s;
      if (val_s == {STAT_W{1'b0}}) begin
        any_zero_s = 1'b1;
      end else begin
        any_zero_s = any_zero_s;
      end
    end
  end

  // Prescaler and LFSR; tick is raised for the cycle after the prescaler wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= {PRE_W{1'b0}};
      lfsr_r  <= LFSR_SEED;
      tick_r  <= 1'b0;
    end else if (bus.ena) begin
      lfsr_r <= lfsr_next(lfsr_r);
      if (presc_r == PRE_LAST) begin
        presc_r <= {PRE_W{1'b0}};
        tick_r  <= 1'b1;
      end else begin
        presc_r <= presc_r + PRE_W'(1);
        tick_r  <= 1'b0;
      end
    end else begin
      presc_r <= presc_r;
      lfsr_r  <= lfsr_r;
      tick_r  <= tick_r;
    end
  end

  // Stat registers, low flags and vitality state; the FSM only moves on decay ticks or revive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stats_r <= INIT_FLAT;
      low_r   <= low_of(INIT_FLAT);
      state_r <= ST_ALIVE;
      cnt_r   <= {CNT_W{1'b0}};
    end else if (!bus.ena) begin
      stats_r <= stats_r;
      low_r   <= low_r;
      state_r <= state_r;
      cnt_r   <= cnt_r;
    end else if (dead_s) begin
      if (bus.revive) begin
        stats_r <= INIT_FLAT;
        low_r   <= low_of(INIT_FLAT);
        state_r <= ST_ALIVE;
        cnt_r   <= {CNT_W{1'b0}};
      end else begin
        stats_r <= stats_r;
        low_r   <= low_r;
        state_r <= state_r;
        cnt_r   <= cnt_r;
      end
    end else begin
      stats_r <= stats_nxt_s;
      low_r   <= low_of(stats_nxt_s);
      if (decay_s) begin
        case (state_r)
          ST_ALIVE: begin
            if (any_zero_s) begin
              state_r <= (DEATH_TICKS <= 1) ? ST_DEAD : ST_SICK;
              cnt_r   <= CNT_W'(1);
            end else begin
              state_r <= ST_ALIVE;
              cnt_r   <= {CNT_W{1'b0}};
            end
          end
          ST_SICK: begin
            if (!any_zero_s) begin
              state_r <= ST_ALIVE;
              cnt_r   <= {CNT_W{1'b0}};
            end else if (32'(cnt_inc_s) >= 32'(DEATH_TICKS)) begin
              state_r <= ST_DEAD;
              cnt_r   <= cnt_inc_s;
            end else begin
              state_r <= ST_SICK;
              cnt_r   <= cnt_inc_s;
            end
          end
          default: begin
            state_r <= ST_ALIVE;
            cnt_r   <= {CNT_W{1'b0}};
          end
        endcase
      end else begin
        state_r <= state_r;
        cnt_r   <= cnt_r;
      end
    end
  end

  assign bus.action_ready = ready_s;
  assign bus.stats_flat   = stats_r;
  assign bus.low_flags    = low_r;
  assign bus.vital_state  = state_r;
  assign bus.tick         = tick_r & bus.ena;

endmodule

// File: tb/tb_pet_stats_engine.sv
// Scoreboard bench for pet_stats_engine: one deterministic-decay instance and one LFSR-decay instance.
module tb_pet_stats_engine;
  localparam int NS = 6;
  localparam int SW = 4;
  localparam int TC = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pet_stats_engine_if #(.NUM_STATS(NS), .STAT_W(SW)) bd ();
  pet_stats_engine_if #(.NUM_STATS(NS), .STAT_W(SW)) br ();

  pet_stats_engine #(.NUM_STATS(NS), .STAT_W(SW), .TICK_COUNT(TC), .INIT_VALUE(8), .BOOST(3),
    .LOW_THRESH(3), .DEATH_TICKS(4), .DECAY_RANDOM(0), .LFSR_SEED(32'h00001000))
    dut_d (.clk(clk), .rst_n(rst_n), .bus(bd.slave));

  pet_stats_engine #(.NUM_STATS(NS), .STAT_W(SW), .TICK_COUNT(TC), .INIT_VALUE(8), .BOOST(3),
    .LOW_THRESH(3), .DEATH_TICKS(4), .DECAY_RANDOM(1), .LFSR_SEED(32'h00001000))
    dut_r (.clk(clk), .rst_n(rst_n), .bus(br.slave));

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  string       nm_q[$];

  function automatic logic [23:0] all_v(input logic [3:0] v);
    logic [23:0] r;
    for (int i = 0; i < NS; i++) r[i*SW +: SW] = v;
    return r;
  endfunction

  task automatic do_reset();
    bd.ena = 1'b1; bd.action_valid = 1'b0; bd.action_id = 4'd0; bd.revive = 1'b0;
    br.ena = 1'b1; br.action_valid = 1'b0; br.action_id = 4'd0; br.revive = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_tick();
    bit seen = 1'b0;
    for (int n = 0; n < 2 * TC && !seen; n++) begin
      @(negedge clk);
      if (bd.tick === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL tick_timeout: got no tick, required one within %0d cycles", 2 * TC);
    end
  endtask

  task automatic test_reset();
    logic [63:0] obs[$];
    logic [63:0] e;
    string n;
    do_reset();
    exp_q.push_back(64'(all_v(4'd8))); nm_q.push_back("reset_stats");
    exp_q.push_back(64'd0);            nm_q.push_back("reset_low");
    exp_q.push_back(64'd0);            nm_q.push_back("reset_vital");
    exp_q.push_back(64'd1);            nm_q.push_back("reset_ready");
    exp_q.push_back(64'd0);            nm_q.push_back("reset_tick");
    exp_q.push_back(64'(all_v(4'd8))); nm_q.push_back("reset_stats_rand");
    obs = {64'(bd.stats_flat), 64'(bd.low_flags), 64'(bd.vital_state),
           64'(bd.action_ready), 64'(bd.tick), 64'(br.stats_flat)};
    foreach (obs[k]) begin
      e = exp_q.pop_front(); n = nm_q.pop_front(); checks++;
      if (obs[k] !== e) begin errors++; $display("FAIL %s: got %0h required %0h", n, obs[k], e); end
    end
    for (int c = 1; c <= 5; c++) begin
      exp_q.push_back((c == 4) ? 64'd1 : 64'd0); nm_q.push_back("tick_period");
      if (c == 5) begin exp_q.push_back(64'(all_v(4'd7))); nm_q.push_back("first_decay"); end
      @(negedge clk);
      obs.delete();
      obs.push_back(64'(bd.tick));
      if (c == 5) obs.push_back(64'(bd.stats_flat));
      foreach (obs[k]) begin
        e = exp_q.pop_front(); n = nm_q.pop_front(); checks++;
        if (obs[k] !== e) begin errors++; $display("FAIL %s: got %0h required %0h", n, obs[k], e); end
      end
    end
  endtask

  task automatic test_handshake();
    logic [63:0] obs[$];
    logic [63:0] e;
    string n;
    logic [23:0] want[3] = '{24'h888B88, 24'h888E88, 24'h888F88};
    do_reset();
    bd.action_valid = 1'b1; bd.action_id = 4'd2;
    for (int c = 0; c < 3; c++) begin
      exp_q.push_back(64'(want[c])); nm_q.push_back("boost_stat2");
      exp_q.push_back(64'd0);        nm_q.push_back("boost_low");
      @(negedge clk);
      obs = {64'(bd.stats_flat), 64'(bd.low_flags)};
      foreach (obs[k]) begin
        e = exp_q.pop_front(); n = nm_q.pop_front(); checks++;
        if (obs[k] !== e) begin errors++; $display("FAIL %s: got %0h required %0h", n, obs[k], e); end
      end
    end
    bd.ena = 1'b0; bd.action_id = 4'd0;
    #1;
    exp_q.push_back(64'd0); nm_q.push_back("ena_low_ready");
    obs = {64'(bd.action_ready)};
    for (int c = 0; c < 6; c++) begin
      exp_q.push_back(64'(24'h888F88)); nm_q.push_back("ena_hold_stats");
      exp_q.push_back(64'd0);           nm_q.push_back("ena_hold_tick");
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      obs.push_back(64'(bd.stats_flat));
      obs.push_back(64'(bd.tick));
    end
    bd.ena = 1'b1; bd.action_valid = 1'b0;
    exp_q.push_back(64'd1);           nm_q.push_back("resume_tick");
    exp_q.push_back(64'(24'h777E77)); nm_q.push_back("resume_decay");
    @(negedge clk);
    obs.push_back(64'(bd.tick));
    @(negedge clk);
    obs.push_back(64'(bd.stats_flat));
    foreach (obs[k]) begin
      e = exp_q.pop_front(); n = nm_q.pop_front(); checks++;
      if (obs[k] !== e) begin errors++; $display("FAIL %s: got %0h required %0h", n, obs[k], e); end
    end
  endtask

  task automatic test_collision();
    logic [63:0] obs[$];
    logic [63:0] e;
    string n;
    do_reset();
    for (int t = 0; t < 8; t++) wait_tick();
    exp_q.push_back(64'(all_v(4'd1))); nm_q.push_back("pre_collision");
    obs = {64'(bd.stats_flat)};
    bd.action_valid = 1'b1; bd.action_id = 4'd0;
    exp_q.push_back(64'(24'h000003)); nm_q.push_back("collision_stats");
    exp_q.push_back(64'(6'b111110));  nm_q.push_back("collision_low");
    exp_q.push_back(64'd1);           nm_q.push_back("collision_vital");
    @(negedge clk);
    bd.action_valid = 1'b0;
    obs.push_back(64'(bd.stats_flat));
    obs.push_back(64'(bd.low_flags));
    obs.push_back(64'(bd.vital_state));
    foreach (obs[k]) begin
      e = exp_q.pop_front(); n = nm_q.pop_front(); checks++;
      if (obs[k] !== e) begin errors++; $display("FAIL %s: got %0h required %0h", n, obs[k], e); end
    end
  endtask

  task automatic test_sickness_and_revive();
    logic [63:0] obs[$];
    logic [63:0] e;
    string n;
    do_reset();
    for (int t = 1; t <= 13; t++) begin
      wait_tick();
      if (t == 12) begin bd.action_valid = 1'b1; bd.action_id = 4'd1; end
      exp_q.push_back(64'(all_v(4'((t < 8) ? 8 - t : 0)))); nm_q.push_back("sick_stats");
      exp_q.push_back((t < 8) ? 64'd0 : ((t < 11) ? 64'd1 : 64'd2)); nm_q.push_back("sick_vital");
      exp_q.push_back((t < 11) ? 64'd1 : 64'd0); nm_q.push_back("sick_ready");
      @(negedge clk);
      obs = {64'(bd.stats_flat), 64'(bd.vital_state), 64'(bd.action_ready)};
      foreach (obs[k]) begin
        e = exp_q.pop_front(); n = nm_q.pop_front(); checks++;
        if (obs[k] !== e) begin errors++; $display("FAIL %s tick %0d: got %0h required %0h", n, t, obs[k], e); end
      end
    end
    bd.action_valid = 1'b0;
    bd.revive = 1'b1;
    exp_q.push_back(64'(all_v(4'd8))); nm_q.push_back("revive_stats");
    exp_q.push_back(64'd0);            nm_q.push_back("revive_vital");
    exp_q.push_back(64'd1);            nm_q.push_back("revive_ready");
    @(negedge clk);
    bd.revive = 1'b0;
    obs = {64'(bd.stats_flat), 64'(bd.vital_state), 64'(bd.action_ready)};
    bd.revive = 1'b1;
    exp_q.push_back(64'(all_v(4'd8))); nm_q.push_back("alive_revive_stats");
    exp_q.push_back(64'd0);            nm_q.push_back("alive_revive_vital");
    @(negedge clk);
    bd.revive = 1'b0;
    obs.push_back(64'(bd.stats_flat));
    obs.push_back(64'(bd.vital_state));
    foreach (obs[k]) begin
      e = exp_q.pop_front(); n = nm_q.pop_front(); checks++;
      if (obs[k] !== e) begin errors++; $display("FAIL %s: got %0h required %0h", n, obs[k], e); end
    end
  endtask

  task automatic test_random_decay();
    logic [3:0]  ms[NS];
    logic [31:0] ml;
    logic [1:0]  mst;
    int          mcnt;
    int          v;
    bit          dec;
    bit          anyz;
    logic        mvalid;
    logic        mrev;
    logic [3:0]  mid;
    logic [23:0] flat;
    logic [5:0]  low;
    logic [63:0] e;
    logic [63:0] o;
    string       n;
    do_reset();
    for (int i = 0; i < NS; i++) ms[i] = 4'd8;
    ml = 32'h00001000; mst = 2'b00; mcnt = 0;
    for (int j = 1; j <= 20 * TC + 1; j++) begin
      mvalid = ((j % 5) != 0);
      mid    = 4'((j * 7) % 11);
      mrev   = (mst == 2'b10);
      br.action_valid = mvalid; br.action_id = mid; br.revive = mrev;
      #1;
      checks++;
      if (br.action_ready !== (mst != 2'b10)) begin
        errors++;
        $display("FAIL rand_ready cycle %0d: got %0b required %0b", j, br.action_ready, (mst != 2'b10));
      end
      dec = ((j % TC) == 1) && (j > 1);
      if (mst == 2'b10) begin
        if (mrev) begin
          for (int i = 0; i < NS; i++) ms[i] = 4'd8;
          mst = 2'b00; mcnt = 0;
        end
      end else begin
        anyz = 1'b0;
        for (int i = 0; i < NS; i++) begin
          v = int'(ms[i]);
          if (dec) v = v - 1 - (ml[i] ? 1 : 0);
          if (v < 0) v = 0;
          if (mvalid && (32'(mid) == 32'(i))) v = v + 3;
          if (v > 15) v = 15;
          ms[i] = 4'(v);
          if (v == 0) anyz = 1'b1;
        end
        if (dec) begin
          if (mst == 2'b00) begin
            if (anyz) begin mst = 2'b01; mcnt = 1; end
          end else if (!anyz) begin
            mst = 2'b00; mcnt = 0;
          end else begin
            mcnt = mcnt + 1;
            if (mcnt >= 4) mst = 2'b10;
          end
        end
      end
      ml = {1'b0, ml[31:1]} ^ (ml[0] ? 32'h80200003 : 32'h00000000);
      for (int i = 0; i < NS; i++) begin
        flat[i*SW +: SW] = ms[i];
        low[i] = (ms[i] < 4'd3);
      end
      exp_q.push_back(64'({mst, low, flat})); nm_q.push_back("rand_state");
      @(negedge clk);
      o = 64'({br.vital_state, br.low_flags, br.stats_flat});
      e = exp_q.pop_front(); n = nm_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL %s cycle %0d: got %0h required %0h", n, j, o, e); end
    end
    br.action_valid = 1'b0; br.revive = 1'b0;
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_collision();
    test_sickness_and_revive();
    test_random_decay();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end
endmodule

// File: doc/pet_stats_engine.md
Name: pet_stats_engine

Overview:
Parametrised successor of the pet-stats logic. It holds NUM_STATS saturating counters, each STAT_W bits wide. A prescaled tick decays the counters, with an LFSR-randomised decay amount. Care actions arrive over a valid/ready handshake and boost a selected stat. A vitality FSM (ALIVE/SICK/DEAD) and per-stat low flags drive the status LEDs. The block sits between the input decoder and the display/status driver in the top-level.

Parameters:
NUM_STATS, 6, number of stat counters (1..16)
STAT_W, 4, width of each stat counter
TICK_COUNT, 10_000_000, clock cycles per decay tick (>=2)
INIT_VALUE, 8, reset and revive value of every stat (< 2^STAT_W)
BOOST, 3, increment applied by an accepted action
LOW_THRESH, 3, a stat is "low" when its value is strictly below this threshold
DEATH_TICKS, 4, consecutive SICK ticks before DEAD
DECAY_RANDOM, 1, 1: decay is 1 or 2 per tick from the LFSR; 0: decay is always 1
LFSR_SEED, 32'h00001000, LFSR reset value (must be nonzero)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  global enable; when low, all state including prescaler and LFSR holds
action_valid  in  1  action request
action_id  in  4  index of the target stat
action_ready  out  1  action accept
revive  in  1  single-cycle pulse, honoured only in DEAD
stats_flat  out  NUM_STATS*STAT_W  stat i occupies bits [i*STAT_W +: STAT_W]
low_flags  out  NUM_STATS  bit i set when stat i < LOW_THRESH
vital_state  out  2  00 ALIVE, 01 SICK, 10 DEAD
tick  out  1  one-cycle pulse on each decay tick

Behaviour:
- Reset (async, rst_n=0):
  - every stat = INIT_VALUE, prescaler = 0, LFSR = LFSR_SEED.
  - FSM = ALIVE, sick-tick counter = 0, tick = 0.
  - action_ready = 1; low_flags reflect INIT_VALUE.
- Prescaler: counts 0..TICK_COUNT-1 while ena=1. tick is registered high for exactly the one cycle after the count wraps. Ticks occur every TICK_COUNT cycles.
- LFSR: 32-bit Galois, taps 32'h80200003. Shifts every enabled cycle.
- Decay: on a tick in ALIVE or SICK, each stat i loses d_i.
  - d_i = 1 + (DECAY_RANDOM ? lfsr[i] : 0).
  - Result saturates at 0 and never wraps.
- Action handshake:
  - action_ready = (vital_state != DEAD) combinationally.
  - Transfer occurs when valid && ready on a rising edge. The stat is updated on that same edge; the new value is visible the next cycle.
  - If action_id >= NUM_STATS, the action is accepted and ignored.
  - Valid while not ready is held off; nothing is dropped silently.
- Boost: the stat increases by BOOST and saturates at 2^STAT_W-1.
- Simultaneous tick and action on the same stat: new = sat_max(sat0(s - d) + BOOST). Decay is applied first.
- FSM, evaluated on each tick using post-update stats:
  - ALIVE -> SICK when any stat == 0; the sick counter is set to 1.
  - SICK -> ALIVE when no stat == 0; the counter is cleared.
  - SICK, still with a zero stat: counter increments. When the counter reaches DEATH_TICKS the FSM enters DEAD.
  - DEAD: stats frozen, no decay, action_ready = 0.
  - DEAD + revive: all stats = INIT_VALUE, FSM -> ALIVE next cycle, counter cleared.
  - revive outside DEAD is ignored.
  - An action that brings a zero stat back above 0 does not change the FSM until the next tick.
- ena low: all registers hold, action_ready is forced 0, tick stays 0.
- Reset mid-handshake: the pending action is discarded and state returns to its reset values.

Test Plan:
- Reset check: TICK_COUNT=4, DECAY_RANDOM=0, defaults otherwise, hold ena=1. Required: all stats = 8; tick pulses every 4 cycles; after 1 tick all stats = 7.
- Handshake: action_valid=1, action_id=2 for one cycle. Required: stat2 = INIT_VALUE+3 = 11 next cycle and other stats unchanged. Then stat2 at 14 plus another action gives 15 (saturation).
- Tick/action collision: stat0=1 on a tick cycle with action_id=0. Required: stat0 = 0 + 3 = 3; low_flags[0] = 0 afterwards.
- Sickness and death: no actions, run 8 ticks. Required: all stats 0 and SICK at tick 8; DEAD at tick 11; action_ready = 0; stats stay 0 over further ticks.
- Revive: in DEAD, pulse revive. Required: stats = 8 and vital_state = ALIVE next cycle; revive pulse while ALIVE changes nothing.
- Randomised decay: DECAY_RANDOM=1, seed 32'h00001000. Compare the decay of each stat against a reference LFSR model over 20 ticks; out-of-range action_id=9 is accepted with no stat change.
